// File: rtl/h_bridge_pattern_sequencer_if.sv
// Board-side bundle for the H-bridge pattern sequencer: control inputs,
// the h_bridge drive signals and the multiplexed 7-segment display.
interface h_bridge_pattern_sequencer_if #(
   parameter int NUM_CH = 3,
   parameter int STEP_W = 4
);
   logic              enable;
   logic              clk_select;
   logic              watchdog_in;
   logic              sample_clk;
   logic              sample_tick;
   logic              watchdog;
   logic [NUM_CH-1:0] sw;
   logic [STEP_W-1:0] step;
   logic [6:0]        seg_n;
   logic [NUM_CH:0]   digit_n;

   modport master (
      output enable, clk_select, watchdog_in,
      input  sample_clk, sample_tick, watchdog, sw, step, seg_n, digit_n
   );

   modport slave (
      input  enable, clk_select, watchdog_in,
      output sample_clk, sample_tick, watchdog, sw, step, seg_n, digit_n
   );
endinterface

// File: rtl/h_bridge_pattern_sequencer.sv
// Sample-clock divider, watchdog synchroniser, per-channel toggle-mask switch
// sequencer and multiplexed 7-segment scanner feeding the h_bridge core.
module h_bridge_pattern_sequencer #(
   parameter int                        NUM_CH      = 3,
   parameter int                        STEPS       = 16,
   parameter int                        FAST_DIV    = 25000,
   parameter int                        SLOW_DIV    = 12500000,
   parameter logic [NUM_CH*STEPS-1:0]   TOGGLE_MASK = {16'h2020, 16'h0108, 16'h8000},
   parameter int                        DWELL       = 262144
) (
   input  logic                          clk,
   input  logic                          reset,
   h_bridge_pattern_sequencer_if.slave   io_bus
);

   localparam int STEP_W  = $clog2(STEPS);
   localparam int DIV_MAX = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
   localparam int DIV_W   = $clog2(DIV_MAX + 1);
   localparam int DWELL_W = $clog2(DWELL + 1);
   localparam int DIG_W   = $clog2(NUM_CH + 1);

   function automatic logic [6:0] f_glyph(input int n);
      case (n)
         1:       f_glyph = 7'h79;
         2:       f_glyph = 7'h24;
         3:       f_glyph = 7'h30;
         4:       f_glyph = 7'h19;
         5:       f_glyph = 7'h12;
         6:       f_glyph = 7'h02;
         7:       f_glyph = 7'h78;
         8:       f_glyph = 7'h00;
         9:       f_glyph = 7'h10;
         default: f_glyph = 7'h7F;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Watchdog synchroniser
   // ------------------------------------------------------------------
   logic r_wd_meta;
   logic r_wd_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wd_meta <= 1'b0;
         r_wd_sync <= 1'b0;
      end else begin
         r_wd_meta <= io_bus.watchdog_in;
         r_wd_sync <= r_wd_meta;
      end
   end

   // ------------------------------------------------------------------
   // Sample clock divider
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_sample_clk;
   logic             r_sample_tick;
   logic [DIV_W-1:0] w_lim_m1;

   assign w_lim_m1 = io_bus.clk_select ? DIV_W'(SLOW_DIV - 1) : DIV_W'(FAST_DIV - 1);

   // >= so a switch to a shorter limit wraps immediately instead of running
   // the counter all the way around
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt     <= '0;
         r_sample_clk  <= 1'b0;
         r_sample_tick <= 1'b0;
      end else if (r_div_cnt >= w_lim_m1) begin
         r_div_cnt     <= '0;
         r_sample_clk  <= ~r_sample_clk;
         r_sample_tick <= ~r_sample_clk;
      end else begin
         r_div_cnt     <= r_div_cnt + DIV_W'(1);
         r_sample_tick <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Switch pattern sequencer
   // ------------------------------------------------------------------
   logic [NUM_CH-1:0] r_sw;
   logic [STEP_W-1:0] r_step;
   logic [NUM_CH-1:0] w_toggle;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_toggle
      localparam logic [STEPS-1:0] MASK_C = TOGGLE_MASK[gi*STEPS +: STEPS];
      assign w_toggle[gi] = MASK_C[r_step];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sw   <= '0;
         r_step <= '0;
      end else if (r_sample_tick) begin
         if (!r_wd_sync) begin
            r_sw   <= '0;
            r_step <= '0;
         end else if (io_bus.enable) begin
            r_sw   <= r_sw ^ w_toggle;
            r_step <= r_step + STEP_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Display scanner
   // ------------------------------------------------------------------
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic [DIG_W-1:0]   r_dig;
   logic [6:0]         r_seg_n;
   logic [NUM_CH:0]    r_digit_n;
   logic [6:0]         w_dig_seg [0:NUM_CH];
   logic [6:0]         w_seg_n;
   logic [NUM_CH:0]    w_digit_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dwell_cnt <= '0;
         r_dig       <= '0;
      end else if (r_dwell_cnt == DWELL_W'(DWELL - 1)) begin
         r_dwell_cnt <= '0;
         r_dig       <= (r_dig == DIG_W'(NUM_CH)) ? '0 : r_dig + DIG_W'(1);
      end else begin
         r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_digit
      localparam logic [6:0] GLYPH = f_glyph(gi + 1);
      assign w_dig_seg[gi] = r_sw[gi] ? GLYPH : 7'h7F;
   end
   assign w_dig_seg[NUM_CH] = io_bus.enable ? 7'h06 : 7'h7F;

   always_comb begin
      w_seg_n   = 7'h7F;
      w_digit_n = '1;
      for (int k = 0; k <= NUM_CH; k++) begin
         if (r_dig == DIG_W'(k)) begin
            w_seg_n      = w_dig_seg[k];
            w_digit_n[k] = 1'b0;
         end
      end
   end

   // Segments and digit select share one register stage so they never skew
   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg_n   <= 7'h7F;
         r_digit_n <= '1;
      end else begin
         r_seg_n   <= w_seg_n;
         r_digit_n <= w_digit_n;
      end
   end

   assign io_bus.sample_clk  = r_sample_clk;
   assign io_bus.sample_tick = r_sample_tick;
   assign io_bus.watchdog    = r_wd_sync;
   assign io_bus.sw          = r_sw;
   assign io_bus.step        = r_step;
   assign io_bus.seg_n       = r_seg_n;
   assign io_bus.digit_n     = r_digit_n;

endmodule
